im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DEPTH, default 64, is the maximum number of 32-bit words that may be loaded.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, is a synchronous, active-high reset.
REQ-004 Port start, input, 1 bit, is a one-cycle pulse that begins a load.
REQ-005 Port byte_in, input, 8 bits, carries the incoming program byte.
REQ-006 Port byte_valid, input, 1 bit, means byte_in holds a valid byte.
REQ-007 Port byte_ready, output, 1 bit, means the loader accepts a byte this cycle.
REQ-008 Port im_we, output, 1 bit, is the instruction-memory write strobe.
REQ-009 Port im_addr, output, 16 bits, is the byte address of the word being written (word index × 4, same convention as pc).
REQ-010 Port im_wdata, output, 32 bits, is the assembled instruction word.
REQ-011 Port cpu_hold, output, 1 bit, holds the core stalled while a load is in progress.
REQ-012 Port done, output, 1 bit, means the last load completed successfully.
REQ-013 Port error, output, 1 bit, means the last load was rejected.

Function
REQ-014 The loader SHALL implement states IDLE, LEN, DATA, CHK (present only with the macro), DONE and ERR.
REQ-015 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both high.
REQ-016 byte_ready SHALL be high in LEN, DATA and CHK, and low in all other states.
REQ-017 When start is high in IDLE, DONE or ERR, the loader SHALL go to LEN next cycle, clear done, error and the byte/word counters, and assert cpu_hold; start is ignored in other states.
REQ-018 In LEN, the first transferred byte SHALL be N, the word count.
- N = 0: go to DONE (or to CHK if the macro is defined).
- N > DEPTH: go to ERR with no writes.
- Otherwise: go to DATA.
REQ-019 In DATA, bytes SHALL assemble little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-020 After the fourth byte of a word transfers, im_we SHALL pulse high for exactly one cycle on the next cycle, with im_addr = word_idx<<2 and im_wdata = the assembled word; word_idx then increments.
REQ-021 On the cycle after the write of word N−1, the loader SHALL leave DATA: to CHK if the macro is defined, else to DONE.
REQ-022 A byte SHALL be accepted in the same cycle as an im_we pulse, with no bubble required.
REQ-023 im_addr and im_wdata SHALL hold their last values when im_we is low.
REQ-024 On entering DONE, cpu_hold SHALL drop and done SHALL rise; both hold until the next start.
REQ-025 In ERR, error SHALL be 1 and cpu_hold SHALL remain 1 until the next start or rst.
REQ-026 Words already written before an error or reset SHALL NOT be rolled back.

Reset
REQ-027 While rst is high, the state SHALL be IDLE and byte_ready, im_we, im_addr, im_wdata, cpu_hold, done, error and all counters SHALL be 0.
REQ-028 rst mid-load SHALL abandon the load immediately and drop cpu_hold on the next cycle.

Configuration
REQ-029 With IM_LOADER_CHKSUM_EN defined, one byte SHALL follow the data in state CHK.
- It is compared against the XOR of all data bytes; a zero-word load compares against 0x00.
- Match goes to DONE; mismatch goes to ERR.
REQ-030 With IM_LOADER_CHKSUM_EN undefined, state CHK and the checksum logic SHALL be absent and no trailing byte is consumed.

Verification
REQ-031 Send start, then N=3, then bytes 13 04 30 00 93 04 10 00 13 09 00 01.
- Required: im_we pulses with (addr, data) = (0x0000, 0x00300413), (0x0004, 0x00100493), (0x0008, 0x01000913).
- Required: done=1 and cpu_hold=0 afterwards.
REQ-032 Send N=65 with DEPTH=64 -> error=1, cpu_hold=1, no im_we, byte_ready=0.
REQ-033 Send N=0 -> done=1 within 2 cycles of the length byte (macro undefined).
REQ-034 Toggle byte_valid randomly during a 2-word load -> words are identical to the no-gap case and byte_ready never drops mid-DATA.
REQ-035 Assert rst after the 6th data byte -> next cycle all outputs are 0; a following start with N=1 writes to address 0x0000.
REQ-036 Macro defined, one-word load 0x00802023, trailing byte 0x83 -> done=1; trailing byte 0x82 -> error=1.

Source files
------------

// File: rtl/im_loader.sv
// ============================================================================
// Module   : im_loader
// Purpose  : Byte-stream instruction-memory loader. Receives a word count N,
//            then N little-endian 32-bit words, and writes each word into
//            instruction memory while holding the core stalled.
//            Optional macro IM_LOADER_CHKSUM_EN adds a trailing XOR checksum
//            byte, checked in state CHK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_len  = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
`ifdef IM_LOADER_CHKSUM_EN
    localparam logic [2:0] c_st_chk  = 3'd3;
`endif
    localparam logic [2:0] c_st_done = 3'd4;
    localparam logic [2:0] c_st_err  = 3'd5;

    localparam logic [31:0] c_depth = DEPTH;

    // Where the load goes once the data phase (or an empty load) finishes
`ifdef IM_LOADER_CHKSUM_EN
    localparam logic [2:0] c_st_after_data = c_st_chk;
`else
    localparam logic [2:0] c_st_after_data = c_st_done;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_word_idx;
    logic [7:0]  r_len;
    logic [23:0] r_asm;
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
`ifdef IM_LOADER_CHKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic w_ready;
    logic w_xfer;
    logic w_start_ok;
    logic w_last_word;
    logic w_too_long;

`ifdef IM_LOADER_CHKSUM_EN
    assign w_ready = (r_state == c_st_len) || (r_state == c_st_data) || (r_state == c_st_chk);
`else
    assign w_ready = (r_state == c_st_len) || (r_state == c_st_data);
`endif

    assign w_xfer      = byte_valid && w_ready;
    assign w_start_ok  = start && ((r_state == c_st_idle) || (r_state == c_st_done) ||
                                   (r_state == c_st_err));
    assign w_last_word = ((r_word_idx + 8'd1) == r_len);
    assign w_too_long  = ({24'd0, byte_in} > c_depth);

    assign byte_ready = w_ready;
    assign im_we      = r_we;
    assign im_addr    = r_addr;
    assign im_wdata   = r_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and status outputs decoded from the state
    always_comb begin
        w_next   = r_state;
        cpu_hold = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_next = c_st_len;
            end
            c_st_len: begin
                cpu_hold = 1'b1;
                if (w_xfer) begin
                    if (byte_in == 8'd0) begin
                        w_next = c_st_after_data;
                    end else if (w_too_long) begin
                        w_next = c_st_err;
                    end else begin
                        w_next = c_st_data;
                    end
                end
            end
            c_st_data: begin
                cpu_hold = 1'b1;
                // Leave as the last word's write strobe is registered
                if (w_xfer && (r_byte_cnt == 2'd3) && w_last_word) begin
                    w_next = c_st_after_data;
                end
            end
`ifdef IM_LOADER_CHKSUM_EN
            c_st_chk: begin
                cpu_hold = 1'b1;
                if (w_xfer) begin
                    w_next = (byte_in == r_chk) ? c_st_done : c_st_err;
                end
            end
`endif
            c_st_done: begin
                done = 1'b1;
                if (start) w_next = c_st_len;
            end
            c_st_err: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) w_next = c_st_len;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // Byte assembly, word write strobe, memory address/data and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_word_idx <= 8'd0;
            r_len      <= 8'd0;
            r_asm      <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= 16'd0;
            r_wdata    <= 32'd0;
`ifdef IM_LOADER_CHKSUM_EN
            r_chk      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_byte_cnt <= 2'd0;
                r_word_idx <= 8'd0;
                r_len      <= 8'd0;
                r_asm      <= 24'd0;
`ifdef IM_LOADER_CHKSUM_EN
                r_chk      <= 8'd0;
`endif
            end else if (w_xfer && (r_state == c_st_len)) begin
                r_len <= byte_in;
            end else if (w_xfer && (r_state == c_st_data)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IM_LOADER_CHKSUM_EN
                r_chk      <= r_chk ^ byte_in;
`endif
                case (r_byte_cnt)
                    2'd0: r_asm[7:0]   <= byte_in;
                    2'd1: r_asm[15:8]  <= byte_in;
                    2'd2: r_asm[23:16] <= byte_in;
                    default: begin
                        // Fourth byte completes the word: strobe it out next cycle
                        r_we       <= 1'b1;
                        r_addr     <= {6'd0, r_word_idx, 2'b00};
                        r_wdata    <= {byte_in, r_asm};
                        r_word_idx <= r_word_idx + 8'd1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader. Randomised byte streams with
//            expected memory writes queued at stimulus time and consumed by
//            an independent write monitor. Honours IM_LOADER_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    im_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%h data=%h required none",
                         im_addr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", {16'd0, im_addr}, {16'd0, mon_e.a});
                check("write_data", im_wdata, mon_e.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_hold",  {31'd0, cpu_hold},   32'd1);
        check("start_done",  {31'd0, done},       32'd0);
        check("start_error", {31'd0, error},      32'd0);
        check("start_ready", {31'd0, byte_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            check("ready_in_gap", {31'd0, byte_ready}, 32'd1);
            tick();
        end
        byte_in    = b;
        byte_valid = 1'b1;
        check("byte_ready", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic run_load(input int n, input bit gaps, input bit bad_chk);
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok;
        pulse_start();
        send_byte(n[7:0], gaps);
        if (n > DEPTH) begin
            check("len_err_error", {31'd0, error},      32'd1);
            check("len_err_hold",  {31'd0, cpu_hold},   32'd1);
            check("len_err_ready", {31'd0, byte_ready}, 32'd0);
            check("len_err_done",  {31'd0, done},       32'd0);
            repeat (3) tick();
            check("len_err_sticky", {31'd0, error}, 32'd1);
            return;
        end
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = (words.size() > 0) ? words.pop_front() : $urandom;
            exp_q.push_back('{a: 16'(i * 4), d: w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gaps);
                x = x ^ w[8*k +: 8];
            end
        end
`ifdef IM_LOADER_CHKSUM_EN
        send_byte(bad_chk ? (x ^ 8'h01) : x, gaps);
        ok = !bad_chk;
`else
        ok = 1'b1;
`endif
        check("end_done",  {31'd0, done},       {31'd0, ok});
        check("end_error", {31'd0, error},      {31'd0, !ok});
        check("end_hold",  {31'd0, cpu_hold},   {31'd0, !ok});
        check("end_ready", {31'd0, byte_ready}, 32'd0);
        repeat (2) tick();
        check("writes_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, im_we},      32'd0);
        check({tag, "_addr"},  {16'd0, im_addr},    32'd0);
        check({tag, "_wdata"}, im_wdata,            32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
        check({tag, "_done"},  {31'd0, done},       32'd0);
        check({tag, "_error"}, {31'd0, error},      32'd0);
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Directed three-word program
        words = '{32'h00300413, 32'h00100493, 32'h01000913};
        run_load(3, 1'b0, 1'b0);

        // Length one beyond capacity is rejected with no writes
        run_load(DEPTH + 1, 1'b0, 1'b0);

        // Empty load
        run_load(0, 1'b0, 1'b0);

        // Two-word load with random valid gaps
        run_load(2, 1'b1, 1'b0);

        // Reset after the sixth data byte of a two-word load
        pulse_start();
        send_byte(8'd2, 1'b0);
        w0 = $urandom;
        w1 = $urandom;
        exp_q.push_back('{a: 16'h0000, d: w0});
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b0);
        for (int k = 0; k < 2; k++) send_byte(w1[8*k +: 8], 1'b0);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        run_load(1, 1'b0, 1'b0);

`ifdef IM_LOADER_CHKSUM_EN
        words = '{32'h00802023};
        run_load(1, 1'b0, 1'b0);
        words = '{32'h00802023};
        run_load(1, 1'b0, 1'b1);
`endif

        // Full-capacity load
        run_load(DEPTH, 1'b1, 1'b0);

        // Random loads
        for (int r = 0; r < 8; r++) begin
`ifdef IM_LOADER_CHKSUM_EN
            run_load(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
`else
            run_load(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);
`endif
        end

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
